// File: rtl/sequence_checker.sv
// Receive-side checker for the 8-byte AF BC E2 78 FF E2 0B 8D pattern: hunts for AF, verifies, then flywheels.
// Statistics counters exist only when SEQ_CHECKER_STATS_EN is defined; otherwise they read 0.
module sequence_checker #(
  parameter int SYNC_LEN   = 2,
  parameter int MISS_LIMIT = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       data,
  output logic             locked,
  output logic [2:0]       pos,
  output logic             match,
  output logic             mismatch,
  output logic             seq_done,
  output logic [CNT_W-1:0] seq_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] START_BYTE = 8'hAF;
  localparam logic [3:0] SYNC_G     = 4'(SYNC_LEN);
  localparam logic [3:0] MISS_L     = 4'(MISS_LIMIT);

  state_t     state;
  logic [3:0] good;
  logic [3:0] miss;
  logic [7:0] expected;

  always_comb begin
    expected = 8'h00;
    case (pos)
      3'd0: expected = 8'hAF;
      3'd1: expected = 8'hBC;
      3'd2: expected = 8'hE2;
      3'd3: expected = 8'h78;
      3'd4: expected = 8'hFF;
      3'd5: expected = 8'hE2;
      3'd6: expected = 8'h0B;
      3'd7: expected = 8'h8D;
      default: expected = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HUNT;
      locked   <= 1'b0;
      pos      <= 3'd0;
      good     <= 4'd0;
      miss     <= 4'd0;
      match    <= 1'b0;
      mismatch <= 1'b0;
      seq_done <= 1'b0;
`ifdef SEQ_CHECKER_STATS_EN
      seq_count <= '0;
      err_count <= '0;
`endif
    end else begin
      match    <= 1'b0;
      mismatch <= 1'b0;
      seq_done <= 1'b0;
      if (enable) begin
        case (state)
          HUNT: begin
            // Only AF can start alignment; E2 appears twice in the pattern.
            if (data == START_BYTE) begin
              pos  <= 3'd1;
              good <= 4'd1;
              if (SYNC_LEN == 1) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= 4'd0;
              end else begin
                state <= VERIFY;
              end
            end
          end

          VERIFY: begin
            if (data == expected) begin
              match <= 1'b1;
              pos   <= pos + 3'd1;
              good  <= good + 4'd1;
              if (good + 4'd1 >= SYNC_G) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= 4'd0;
              end
            end else if (data == START_BYTE) begin
              mismatch <= 1'b1;
              pos      <= 3'd1;
              good     <= 4'd1;
            end else begin
              mismatch <= 1'b1;
              state    <= HUNT;
              pos      <= 3'd0;
              good     <= 4'd0;
            end
          end

          LOCKED: begin
            pos <= pos + 3'd1;
            if (data == expected) begin
              match <= 1'b1;
              miss  <= 4'd0;
              if (pos == 3'd7) begin
                seq_done <= 1'b1;
`ifdef SEQ_CHECKER_STATS_EN
                if (seq_count != '1) seq_count <= seq_count + 1'b1;
`endif
              end
            end else begin
              mismatch <= 1'b1;
`ifdef SEQ_CHECKER_STATS_EN
              if (err_count != '1) err_count <= err_count + 1'b1;
`endif
              // The byte that drops lock is not re-examined as a start marker.
              if (miss + 4'd1 >= MISS_L) begin
                state  <= HUNT;
                locked <= 1'b0;
                pos    <= 3'd0;
                miss   <= 4'd0;
                good   <= 4'd0;
              end else begin
                miss <= miss + 4'd1;
              end
            end
          end

          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            pos    <= 3'd0;
            good   <= 4'd0;
            miss   <= 4'd0;
          end
        endcase
      end
    end
  end

`ifndef SEQ_CHECKER_STATS_EN
  assign seq_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// Self-checking bench for sequence_checker: directed scenarios plus random pattern/noise traffic
// compared every cycle against a behavioural model of the alignment rules.
module tb_sequence_checker;

  localparam int SYNC_LEN   = 2;
  localparam int MISS_LIMIT = 3;
  localparam int CNT_W      = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef SEQ_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [7:0]       data;
  logic             locked;
  logic [2:0]       pos;
  logic             match;
  logic             mismatch;
  logic             seq_done;
  logic [CNT_W-1:0] seq_count;
  logic [CNT_W-1:0] err_count;

  sequence_checker #(
    .SYNC_LEN  (SYNC_LEN),
    .MISS_LIMIT(MISS_LIMIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .data     (data),
    .locked   (locked),
    .pos      (pos),
    .match    (match),
    .mismatch (mismatch),
    .seq_done (seq_done),
    .seq_count(seq_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] pat [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  // Model: mode 0 = hunting, 1 = verifying, 2 = locked
  int m_mode, m_pos, m_good, m_miss, m_seq, m_err;
  bit m_match, m_mismatch, m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit en, input logic [7:0] d);
    m_match = 0; m_mismatch = 0; m_done = 0;
    if (r) begin
      m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_seq = 0; m_err = 0;
    end else if (en) begin
      if (m_mode == 0) begin
        if (d == 8'hAF) begin
          m_pos = 1; m_good = 1;
          m_mode = (SYNC_LEN == 1) ? 2 : 1;
          m_miss = 0;
        end
      end else if (m_mode == 1) begin
        if (d == pat[m_pos]) begin
          m_match = 1;
          m_pos = (m_pos + 1) % 8;
          m_good++;
          if (m_good >= SYNC_LEN) begin m_mode = 2; m_miss = 0; end
        end else begin
          m_mismatch = 1;
          if (d == 8'hAF) begin m_pos = 1; m_good = 1; end
          else begin m_mode = 0; m_pos = 0; m_good = 0; end
        end
      end else begin
        if (d == pat[m_pos]) begin
          m_match = 1; m_miss = 0;
          if (m_pos == 7) begin m_done = 1; if (m_seq < CNT_MAX) m_seq++; end
        end else begin
          m_mismatch = 1; m_miss++;
          if (m_err < CNT_MAX) m_err++;
        end
        m_pos = (m_pos + 1) % 8;
        if (m_miss >= MISS_LIMIT) begin m_mode = 0; m_pos = 0; m_miss = 0; m_good = 0; end
      end
    end
  endtask

  // Called on a falling edge; drives, lets the rising edge sample, checks on the next falling edge.
  task automatic step(input bit r, input bit en, input logic [7:0] d);
    reset = r; enable = en; data = d;
    @(posedge clk);
    model(r, en, d);
    @(negedge clk);
    chk("locked",    32'(locked),    32'(m_mode == 2));
    chk("pos",       32'(pos),       32'(m_pos));
    chk("match",     32'(match),     32'(m_match));
    chk("mismatch",  32'(mismatch),  32'(m_mismatch));
    chk("seq_done",  32'(seq_done),  32'(m_done));
    chk("seq_count", 32'(seq_count), STATS ? 32'(m_seq) : 32'd0);
    chk("err_count", 32'(err_count), STATS ? 32'(m_err) : 32'd0);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b1, d);
  endtask

  task automatic send_seq(input int from, input int upto);
    for (int i = from; i <= upto; i++) send(pat[i]);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; data = 8'h00;
    m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_seq = 0; m_err = 0;
    @(negedge clk);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hAF);

    // clean lock
    send(8'hAF);
    chk("verify_not_locked", 32'(locked), 32'd0);
    send(8'hBC);
    chk("lock_after_bc", 32'(locked), 32'd1);
    send_seq(2, 7);
    chk("first_seq_count", 32'(seq_count), STATS ? 32'd1 : 32'd0);
    chk("first_pos_wrap", 32'(pos), 32'd0);

    // enable gap at pos 4
    send_seq(0, 3);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'(i * 37));
      chk("gap_pos_held", 32'(pos), 32'd4);
    end
    send(8'hFF);
    chk("resume_match", 32'(match), 32'd1);
    send_seq(5, 7);

    // single error
    send_seq(0, 2);
    send(8'h79);
    chk("single_err_pulse", 32'(mismatch), 32'd1);
    chk("single_err_locked", 32'(locked), 32'd1);
    send(8'hFF);
    chk("after_err_match", 32'(match), 32'd1);
    send_seq(5, 7);

    // loss of lock from a fresh start
    step(1'b1, 1'b0, 8'h00);
    send(8'hAF); send(8'hBC);
    send(8'h00); send(8'h00); send(8'h00);
    chk("loss_unlocked", 32'(locked), 32'd0);
    chk("loss_err_count", 32'(err_count), STATS ? 32'd3 : 32'd0);
    send(8'hAF); send(8'hBC);
    chk("relock", 32'(locked), 32'd1);

    // hunt noise
    step(1'b1, 1'b0, 8'h00);
    send(8'hE2); send(8'h0B); send(8'h8D); send(8'hE2);
    send(8'hAF); send(8'h00);
    chk("verify_fail_hunt", 32'(pos), 32'd0);
    send(8'hAF); send(8'hBC); send(8'h00);

    // reset mid-lock at pos 5 with two sequences done
    step(1'b1, 1'b0, 8'h00);
    send_seq(0, 7); send_seq(0, 7); send_seq(0, 4);
    chk("pre_reset_pos", 32'(pos), 32'd5);
    step(1'b1, 1'b1, 8'hE2);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_seq_count", 32'(seq_count), 32'd0);

    // seq_count saturation on a long clean stream
    for (int i = 0; i < 8 * 260 + 2; i++) send(pat[i % 8]);

    // random pattern/noise/gap/reset traffic
    begin
      int idx = 0;
      for (int n = 0; n < 4000; n++) begin
        bit r, en;
        logic [7:0] d;
        r  = ($urandom_range(0, 599) == 0);
        en = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 99) < 88) d = pat[idx % 8];
        else d = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 199) == 0) idx = idx + int'($urandom_range(1, 7));
        if (en) idx++;
        step(r, en, d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
